// File: rtl/lipo_emu_pkg.sv
// Shared types and constants for the Li-Po battery emulator: FSM state
// encoding, datapath widths and the OCV breakpoint table (1 mV LSB).
package lipo_emu_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_UPDATE = 2'd1,
      ST_OUTPUT = 2'd2
   } state_t;

   localparam int I_W     = 10;   // forced current code, 1 mA LSB
   localparam int VCODE_W = 12;   // sensed voltage code, 1 mV LSB
   localparam int SOC_W   = 7;    // state of charge, 0..100 %
   localparam int SUB_W   = 17;   // sub-percent charge accumulator, mA*s
   localparam int DROP_W  = 20;   // i * ESR product
   localparam int SUM_W   = 13;   // ocv + drop before saturation
   localparam int PCT_W   = 4;    // tens / ones digit of the SOC

   localparam logic [VCODE_W-1:0] VCODE_MAX = 12'd4095;

   // OCV at 0 %, 10 %, ... 100 % SOC; the top entry exceeds 12 bits,
   // so the table is carried at the pre-saturation width.
   localparam logic [SUM_W-1:0] BP [11] = '{
      13'd3000, 13'd3450, 13'd3600, 13'd3680, 13'd3730, 13'd3780,
      13'd3850, 13'd3920, 13'd4000, 13'd4100, 13'd4200
   };

   // Tens digit of a percentage (0..10 for legal values).
   function automatic logic [PCT_W-1:0] pct_tens(input logic [SOC_W-1:0] p);
      return PCT_W'(p / 7'd10);
   endfunction

   // Ones digit of a percentage (0..9).
   function automatic logic [PCT_W-1:0] pct_ones(input logic [SOC_W-1:0] p);
      return PCT_W'(p % 7'd10);
   endfunction

endpackage

// File: rtl/lipo_ocv_lut.sv
// Combinational open-circuit-voltage lookup: linear interpolation between
// the 10 % breakpoints, truncating. tens >= 10 yields the top breakpoint.
module lipo_ocv_lut
   import lipo_emu_pkg::*;
(
   input  logic [PCT_W-1:0] tens,
   input  logic [PCT_W-1:0] ones,
   output logic [SUM_W-1:0] ocv
);

   // Per-segment base and slope, padded to the full 4-bit index range so
   // that out-of-range digits land on a flat segment at the top breakpoint.
   logic [SUM_W-1:0] seg_base  [16];
   logic [8:0]       seg_delta [16];

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_seg
         if (gi < 10) begin : g_live
            assign seg_base[gi]  = BP[gi];
            assign seg_delta[gi] = 9'(BP[gi+1] - BP[gi]);
         end else begin : g_flat
            assign seg_base[gi]  = BP[10];
            assign seg_delta[gi] = '0;
         end
      end
   endgenerate

   logic [SUM_W-1:0] interp_prod;
   logic [SUM_W-1:0] interp;

   // base + (delta * ones) / 10; the product is at most 450*9 = 4050.
   always_comb begin
      interp_prod = SUM_W'(seg_delta[tens]) * SUM_W'(ones);
      interp      = interp_prod / SUM_W'(10);
      ocv         = seg_base[tens] + interp;
   end

endmodule

// File: rtl/lipo_batt_emu.sv
// Li-Po battery emulator: integrates the forced charge current into stored
// charge once per model second and returns the sensed voltage (OCV + ESR
// drop) as a one-cycle pulse per tick.
// Optional self-discharge of 1 mA*s per idle tick: define LIPO_EMU_SELFDIS_EN.
// CAP_MAH must keep CAP_MAH*36 + 1023 within the 17-bit accumulator.
module lipo_batt_emu
   import lipo_emu_pkg::*;
#(
   parameter int CAP_MAH  = 450,
   parameter int TICK_DIV = 1000,
   parameter int ESR_MOHM = 100,
   parameter int INIT_PCT = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [I_W-1:0]     i_code,
   input  logic               i_valid,
   output logic               i_ready,
   output logic [VCODE_W-1:0] vbat_code,
   output logic               vbat_valid,
   output logic [SOC_W-1:0]   soc_pct,
   output logic               full
);

   localparam int PS_W = $clog2(TICK_DIV);
   localparam int PCT_STEP = CAP_MAH * 36;
   localparam logic [SUB_W-1:0] STEP_V = SUB_W'(PCT_STEP);
   localparam logic [PS_W-1:0]  PS_TERM = PS_W'(TICK_DIV - 1);
   localparam logic [SOC_W-1:0] SOC_INIT = SOC_W'(INIT_PCT);
   localparam logic [SOC_W-1:0] SOC_FULL = 7'd100;

   state_t             state_reg, state_next;
   logic [PS_W-1:0]    ps_reg, ps_next;
   logic [I_W-1:0]     i_reg, i_next;
   logic [SUB_W-1:0]   sub_reg, sub_next;
   logic [SOC_W-1:0]   soc_reg, soc_next;
   logic [VCODE_W-1:0] vhold_reg, vhold_next;

   logic [SUB_W-1:0]   sum;
   logic               drain;
   logic               full_int;
   logic [PCT_W-1:0]   tens, ones;
   logic [SUM_W-1:0]   ocv;
   logic [DROP_W-1:0]  drop_prod, drop;
   logic [SUM_W-1:0]   vsum;
   logic [VCODE_W-1:0] vcalc;

   assign full_int   = (soc_reg == SOC_FULL);
   assign full       = full_int;
   assign soc_pct    = soc_reg;
   assign i_ready    = (state_reg != ST_UPDATE);
   assign vbat_valid = (state_reg == ST_OUTPUT);
   // The freshly computed code is presented during OUTPUT and held after it.
   assign vbat_code  = (state_reg == ST_OUTPUT) ? vcalc : vhold_reg;

   assign tens = pct_tens(soc_reg);
   assign ones = pct_ones(soc_reg);

   lipo_ocv_lut u_ocv_lut (
      .tens (tens),
      .ones (ones),
      .ocv  (ocv)
   );

   // Tick sequencer: prescaler counts enabled RUN cycles; a started tick
   // always runs UPDATE then OUTPUT regardless of en.
   always_comb begin
      state_next = state_reg;
      ps_next    = ps_reg;
      case (state_reg)
         ST_RUN: begin
            if (en) begin
               if (ps_reg == PS_TERM) begin
                  ps_next    = '0;
                  state_next = ST_UPDATE;
               end else begin
                  ps_next = ps_reg + PS_W'(1);
               end
            end
         end
         ST_UPDATE: state_next = ST_OUTPUT;
         ST_OUTPUT: state_next = ST_RUN;
         default:   state_next = ST_RUN;
      endcase
   end

   // Current handshake: the code is captured whenever the model is not
   // integrating, so a value taken during OUTPUT only affects the next tick.
   always_comb begin
      i_next = i_reg;
      if (i_valid && i_ready) begin
         i_next = i_code;
      end
   end

   // Charge integrator: at most one percent step per tick because the
   // percent step always exceeds the largest current code.
   always_comb begin
      sub_next = sub_reg;
      soc_next = soc_reg;
      sum      = sub_reg + SUB_W'(i_reg);
      drain    = 1'b0;
`ifdef LIPO_EMU_SELFDIS_EN
      drain    = (i_reg == '0);
`endif
      if (state_reg == ST_UPDATE) begin
         if (drain) begin
            if (sub_reg != '0) begin
               sub_next = sub_reg - SUB_W'(1);
            end else if (soc_reg != '0) begin
               soc_next = soc_reg - SOC_W'(1);
               sub_next = STEP_V - SUB_W'(1);
            end
         end else if (!full_int) begin
            if (sum >= STEP_V) begin
               soc_next = soc_reg + SOC_W'(1);
               // Reaching 100 % discards the remainder.
               sub_next = (soc_reg == SOC_FULL - SOC_W'(1)) ? '0 : (sum - STEP_V);
            end else begin
               sub_next = sum;
            end
         end
      end
   end

   // Sensed voltage: OCV plus truncated ESR drop, saturated to 12 bits.
   always_comb begin
      drop_prod  = DROP_W'(i_reg) * DROP_W'(ESR_MOHM);
      drop       = drop_prod / DROP_W'(1000);
      vsum       = ocv + drop[SUM_W-1:0];
      vcalc      = (vsum > SUM_W'(VCODE_MAX)) ? VCODE_MAX : vsum[VCODE_W-1:0];
      vhold_next = (state_reg == ST_OUTPUT) ? vcalc : vhold_reg;
   end

   // State registers; reset aborts any tick in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_RUN;
         ps_reg    <= '0;
         i_reg     <= '0;
         sub_reg   <= '0;
         soc_reg   <= SOC_INIT;
         vhold_reg <= '0;
      end else begin
         state_reg <= state_next;
         ps_reg    <= ps_next;
         i_reg     <= i_next;
         sub_reg   <= sub_next;
         soc_reg   <= soc_next;
         vhold_reg <= vhold_next;
      end
   end

endmodule

// File: tb/tb_lipo_batt_emu.sv
// Testbench for lipo_batt_emu: four instances with different initial SOC
// share one stimulus stream; a charge-level reference model predicts every
// output each cycle.
module tb_lipo_batt_emu;

   localparam int TICK_DIV = 4;
   localparam int CAP_MAH  = 50;
   localparam int ESR_MOHM = 100;
   localparam int STEP     = CAP_MAH * 36;
   localparam int NI       = 4;
   localparam int BPM [11] = '{3000, 3450, 3600, 3680, 3730, 3780,
                               3850, 3920, 4000, 4100, 4200};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       i_valid = 1'b0;
   logic [9:0] i_code = '0;

   logic        i_ready    [NI];
   logic [11:0] vbat_code  [NI];
   logic        vbat_valid [NI];
   logic [6:0]  soc_pct    [NI];
   logic        full       [NI];

   always #5 clk = ~clk;

   function automatic int init_of(input int k);
      case (k)
         0:       return 0;
         1:       return 5;
         2:       return 100;
         default: return 1;
      endcase
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < NI; gi++) begin : g_dut
         lipo_batt_emu #(
            .CAP_MAH  (CAP_MAH),
            .TICK_DIV (TICK_DIV),
            .ESR_MOHM (ESR_MOHM),
            .INIT_PCT (init_of(gi))
         ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .en         (en),
            .i_code     (i_code),
            .i_valid    (i_valid),
            .i_ready    (i_ready[gi]),
            .vbat_code  (vbat_code[gi]),
            .vbat_valid (vbat_valid[gi]),
            .soc_pct    (soc_pct[gi]),
            .full       (full[gi])
         );
      end
   endgenerate

   // Reference model: total stored charge in mA*s per instance, plus the
   // tick timing (enabled cycles counted, then two completion cycles).
   longint m_q     [NI];
   int     m_vhold [NI];
   int     m_ireg;
   int     m_cnt;
   int     m_phase;   // 0 counting, 1 integrating, 2 presenting
   bit     last_acc;

   int n_chk = 0;
   int n_err = 0;

   function automatic int exp_v(input longint q, input int ireg);
      int soc, tens, ones, ocv, v;
      soc  = int'(q / STEP);
      tens = soc / 10;
      ones = soc % 10;
      if (tens >= 10) ocv = BPM[10];
      else            ocv = BPM[tens] + ((BPM[tens+1] - BPM[tens]) * ones) / 10;
      v = ocv + (ireg * ESR_MOHM) / 1000;
      return (v > 4095) ? 4095 : v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt   = 0;
      m_phase = 0;
      m_ireg  = 0;
      for (int k = 0; k < NI; k++) begin
         m_q[k]     = longint'(init_of(k)) * STEP;
         m_vhold[k] = 0;
      end
   endtask

   task automatic charge(input int k);
      bit sd;
      sd = 1'b0;
`ifdef LIPO_EMU_SELFDIS_EN
      sd = (m_ireg == 0);
`endif
      if (sd) begin
         if (m_q[k] > 0) m_q[k] = m_q[k] - 1;
      end else if (m_q[k] < 100 * STEP) begin
         m_q[k] = m_q[k] + m_ireg;
         if (m_q[k] > 100 * STEP) m_q[k] = 100 * STEP;
      end
   endtask

   // One clock: capture inputs, advance the model on the edge, then compare
   // every output of every instance 1 time unit later.
   task automatic cycle();
      bit r, e, v, rdy;
      int c;
      r = rst; e = en; v = i_valid; c = int'(i_code);
      rdy = (m_phase != 1);
      @(posedge clk);
      last_acc = 1'b0;
      if (r) begin
         model_reset();
      end else begin
         case (m_phase)
            0: if (e) begin
                  if (m_cnt == TICK_DIV - 1) begin m_cnt = 0; m_phase = 1; end
                  else m_cnt++;
               end
            1: begin
                  for (int k = 0; k < NI; k++) charge(k);
                  m_phase = 2;
               end
            default: begin
                  for (int k = 0; k < NI; k++) m_vhold[k] = exp_v(m_q[k], m_ireg);
                  m_phase = 0;
               end
         endcase
         if (v && rdy) begin
            m_ireg   = c;
            last_acc = 1'b1;
         end
      end
      #1;
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("valid%0d", k), vbat_valid[k], (m_phase == 2) ? 1 : 0);
         chk($sformatf("ready%0d", k), i_ready[k], (m_phase != 1) ? 1 : 0);
         chk($sformatf("vbat%0d", k), vbat_code[k],
             (m_phase == 2) ? exp_v(m_q[k], m_ireg) : m_vhold[k]);
         chk($sformatf("soc%0d", k), soc_pct[k], int'(m_q[k] / STEP));
         chk($sformatf("full%0d", k), full[k], (m_q[k] / STEP == 100) ? 1 : 0);
      end
      if (m_phase == 2)
         $display("tick: i=%0d soc=%0d/%0d/%0d/%0d vbat=%0d/%0d/%0d/%0d", m_ireg,
                  soc_pct[0], soc_pct[1], soc_pct[2], soc_pct[3],
                  vbat_code[0], vbat_code[1], vbat_code[2], vbat_code[3]);
   endtask

   task automatic wait_pulses(input string tag, input int n);
      int got, cyc;
      got = 0; cyc = 0;
      while (got < n && cyc < n * (TICK_DIV + 2) + 20) begin
         cycle();
         cyc++;
         if (m_phase == 2) got++;
      end
      chk(tag, got, n);
   endtask

   task automatic wait_phase(input string tag, input int ph, input int cnt);
      bit hit;
      hit = (m_phase == ph && (ph != 0 || m_cnt == cnt));
      for (int n = 0; n < 30 && !hit; n++) begin
         cycle();
         hit = (m_phase == ph && (ph != 0 || m_cnt == cnt));
      end
      chk(tag, hit, 1);
   endtask

   task automatic send(input string tag, input int code);
      bit done;
      i_valid = 1'b1;
      i_code  = 10'(code);
      done    = 1'b0;
      for (int n = 0; n < 12 && !done; n++) begin
         cycle();
         done = last_acc;
      end
      i_valid = 1'b0;
      chk(tag, done, 1);
   endtask

   initial begin
      int lat, pulses, newc;
      model_reset();

      // Reset
      rst = 1'b1;
      repeat (3) cycle();
      chk("reset_vbat", vbat_code[0], 0);
      chk("reset_soc_init5", soc_pct[1], 5);
      chk("reset_full_init100", full[2], 1);
      rst = 1'b0;

      // Idle current: first pulse 5 cycles after en
      en  = 1'b1;
      lat = 0;
      for (int n = 1; n <= 12 && lat == 0; n++) begin
         cycle();
         if (vbat_valid[0] === 1'b1) lat = n;
      end
      chk("first_pulse_latency", lat, 5);
      chk("idle_vbat_init0", vbat_code[0], 3000);
`ifdef LIPO_EMU_SELFDIS_EN
      chk("idle_vbat_init5", vbat_code[1], 3180);
      chk("selfdis_soc_init1", soc_pct[3], 0);
`else
      chk("idle_vbat_init5", vbat_code[1], 3225);
      chk("idle_soc_init1", soc_pct[3], 1);
`endif
      wait_pulses("idle_pulses", 2);
      chk("idle_soc_init0", soc_pct[0], 0);

      // Charge at 900 mA for 20 ticks
      send("accept_900", 900);
      wait_pulses("charge_pulses", 20);
      chk("charge_soc10", soc_pct[0], 10);
      chk("charge_vbat3540", vbat_code[0], 3540);
      chk("full_soc100", soc_pct[2], 100);
      chk("full_vbat_sat", vbat_code[2], 4095);
      wait_pulses("full_hold_pulses", 30);
      chk("full_hold_soc100", soc_pct[2], 100);

      // New code offered across an UPDATE cycle
      wait_phase("reach_update", 1, 0);
      chk("ready_low_in_update", i_ready[0], 0);
      newc    = $urandom_range(1, 899);
      i_valid = 1'b1;
      i_code  = 10'(newc);
      cycle();
      chk("not_taken_in_update", last_acc, 0);
      chk("output_uses_old_i", vbat_code[0], exp_v(m_q[0], 900));
      cycle();
      chk("taken_after_update", last_acc, 1);
      i_valid = 1'b0;
      wait_pulses("new_i_pulse", 1);
      chk("new_i_vbat", vbat_code[0], exp_v(m_q[0], newc));

      // en low mid-count: no pulses, prescaler resumes
      wait_phase("reach_count2", 0, 2);
      en = 1'b0;
      pulses = 0;
      repeat (10) begin
         cycle();
         if (vbat_valid[0] !== 1'b0) pulses++;
      end
      chk("en_low_no_pulse", pulses, 0);
      en  = 1'b1;
      lat = 0;
      for (int n = 1; n <= 10 && lat == 0; n++) begin
         cycle();
         if (vbat_valid[0] === 1'b1) lat = n;
      end
      chk("resume_latency", lat, 3);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         en      = ($urandom_range(0, 9) != 0);
         i_valid = ($urandom_range(0, 3) == 0);
         i_code  = 10'($urandom_range(0, 1023));
         rst     = ($urandom_range(0, 149) == 0);
         cycle();
      end
      rst = 1'b0; i_valid = 1'b0; en = 1'b1;

      // Reset asserted during UPDATE
      send("accept_pre_rst", 700);
      wait_phase("reach_update_rst", 1, 0);
      rst = 1'b1;
      cycle();
      chk("rst_vbat", vbat_code[0], 0);
      chk("rst_valid", vbat_valid[0], 0);
      chk("rst_ready", i_ready[0], 1);
      chk("rst_soc_init5", soc_pct[1], 5);
      rst = 1'b0;
      wait_pulses("post_rst_pulse", 1);
      chk("post_rst_i_cleared", vbat_code[0], 3000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
